cam_capture: RTL and testbench

Camera front-end. Captures one QQVGA frame of RGB565 byte pairs from the camera parallel bus, converts each pixel to RGB332 and writes it into the frame buffer. The dominant-colour analyser reads that buffer afterwards. Capture is one frame per request: the buffer stays stable while the analyser sums it.

---
 rtl/cam_pkg.sv | 36 +++
 rtl/rgb565_to_332.sv | 38 +++
 rtl/cam_capture.sv | 160 ++++++++++++++++
 tb/tb_cam_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: definitions shared by the camera capture front-end.
//   - cam_state_e   : capture FSM states
//   - QQVGA_*       : default frame geometry (160 x 120 = 19200 pixels)
//   - RGB332_*_LSB  : bit positions of the R/G/B fields in a stored pixel
//   - pack_rgb332() : assembles an RGB332 byte from its three fields
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cam_state_e;

  localparam int QQVGA_H      = 160;
  localparam int QQVGA_V      = 120;
  localparam int QQVGA_PIXELS = 19200;

  // RGB332 layout: {R[2:0], G[2:0], B[1:0]}
  localparam int RGB332_R_LSB = 5;
  localparam int RGB332_G_LSB = 2;
  localparam int RGB332_B_LSB = 0;

  function automatic logic [7:0] pack_rgb332(input logic [2:0] r,
                                             input logic [2:0] g,
                                             input logic [1:0] b);
    logic [7:0] px;
    px = '0;
    px[RGB332_R_LSB +: 3] = r;
    px[RGB332_G_LSB +: 3] = g;
    px[RGB332_B_LSB +: 2] = b;
    return px;
  endfunction

endpackage

// File: rtl/rgb565_to_332.sv
// rgb565_to_332: turns a camera RGB565 byte pair into one RGB332 pixel.
// The first byte (phase 0) carries R[4:0],G[5:3]; only the top three bits of
// each field are kept in a small latch. The second byte (phase 1) carries
// G[2:0],B[4:0]; its B[4:3] completes the pixel combinationally, so pixel_o
// is valid in the cycle the phase-1 byte is on byte_i.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   byte_vld_i  : byte_i holds a camera byte this cycle
//   phase_i     : 0 = first byte of the pair, 1 = second byte
//   byte_i      : camera byte
//   pixel_o     : RGB332 pixel, meaningful while the phase-1 byte is present
module rgb565_to_332
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_vld_i,
  input  logic       phase_i,
  input  logic [7:0] byte_i,
  output logic [7:0] pixel_o
);

  logic [2:0] r_q;
  logic [2:0] g_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
    end else if (byte_vld_i && !phase_i) begin
      r_q <= byte_i[7:5];
      g_q <= byte_i[2:0];
    end
  end

  assign pixel_o = pack_rgb332(r_q, g_q, byte_i[4:3]);

endmodule

// File: rtl/cam_capture.sv
// cam_capture: captures one frame of RGB565 byte pairs per start request,
// converts each pixel to RGB332 and writes it into the frame buffer.
// Ports:
//   clk, rst_n        : camera pixel clock, asynchronous active-low reset
//   start             : one-cycle capture request (ignored while busy)
//   vsync, href       : camera sync signals, synchronous to clk
//   px_data           : camera byte bus
//   mem_wr_en         : one-cycle frame-buffer write strobe
//   mem_addr/mem_data : write address and RGB332 pixel, valid with mem_wr_en
//   busy              : capture in progress (ARM, SYNC, CAPTURE)
//   done              : frame stored; held until the next accepted start
//   frame_err         : with done, the frame had a short line or too few lines
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_PIX   = QQVGA_H,
  parameter int V_LINES = QQVGA_V,
  parameter int ADDR_W  = $clog2(QQVGA_PIXELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        px_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int COL_W  = $clog2(H_PIX + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIX);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

  cam_state_e state_q, state_d;

  logic              vsync_q, href_q, phase_q, short_q;
  logic [COL_W-1:0]  col_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] wr_addr_q, base_q;
  logic              mem_wr_en_q, busy_q, done_q, frame_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_data_q;

  logic       vsync_rise, href_fall, capturing, byte_vld, pix_done, in_window;
  logic [7:0] pixel;

  assign vsync_rise = vsync & ~vsync_q;
  assign href_fall  = ~href & href_q;
  assign capturing  = (state_q == ST_CAPTURE);
  assign byte_vld   = capturing & href;
  assign pix_done   = byte_vld & phase_q;
  assign in_window  = (col_q < COL_MAX) && (line_q < LINE_MAX);

  rgb565_to_332 u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_vld_i (byte_vld),
    .phase_i    (phase_q),
    .byte_i     (px_data),
    .pixel_o    (pixel)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start)      state_d = ST_ARM;
      ST_ARM:     if (vsync)      state_d = ST_SYNC;
      ST_SYNC:    if (!vsync)     state_d = ST_CAPTURE;
      ST_CAPTURE: if (vsync_rise) state_d = ST_DONE;
      ST_DONE:    if (start)      state_d = ST_ARM;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so busy/done change
  // exactly one cycle after the deciding input is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_ARM) || (state_d == ST_SYNC) ||
                 (state_d == ST_CAPTURE);
      done_q  <= (state_d == ST_DONE);
      if (capturing && vsync_rise)
        frame_err_q <= short_q | (line_q < LINE_MAX);
      else if (state_d != ST_DONE)
        frame_err_q <= 1'b0;
    end
  end

  // Counters and address generator. SYNC holds everything cleared so the
  // first CAPTURE cycle starts at line 0, column 0, address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      short_q     <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
      wr_addr_q   <= '0;
      base_q      <= '0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      vsync_q     <= vsync;
      href_q      <= href;
      mem_wr_en_q <= 1'b0;
      if (state_q == ST_SYNC) begin
        phase_q   <= 1'b0;
        short_q   <= 1'b0;
        col_q     <= '0;
        line_q    <= '0;
        wr_addr_q <= '0;
        base_q    <= '0;
      end else if (capturing) begin
        // href low realigns the byte pair, dropping any odd trailing byte
        phase_q <= href ? ~phase_q : 1'b0;
        if (pix_done) begin
          if (col_q < COL_MAX) col_q <= col_q + 1'b1;
          if (in_window) begin
            mem_wr_en_q <= 1'b1;
            mem_addr_q  <= wr_addr_q;
            mem_data_q  <= pixel;
            wr_addr_q   <= wr_addr_q + 1'b1;
          end
        end
        // pix_done needs href high, so it never coincides with a falling edge
        if (href_fall) begin
          if (line_q < LINE_MAX) begin
            line_q    <= line_q + 1'b1;
            if (col_q < COL_MAX) short_q <= 1'b1;
            base_q    <= base_q + LINE_STEP;
            wr_addr_q <= base_q + LINE_STEP;
          end
          col_q <= '0;
        end
      end
    end
  end

  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed bench for cam_capture with a write scoreboard.
// Expected writes are pushed as pixels are driven and popped by a monitor
// on the falling clock edge whenever mem_wr_en is seen.
module tb_cam_capture;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    px_data = 8'h00;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          busy, done, frame_err;

  always #5 clk = ~clk;

  cam_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vsync     (vsync),
    .href      (href),
    .px_data   (px_data),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int tb_line = 0;
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] exp_item;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion from the full RGB565 fields.
  function automatic logic [7:0] rgb_model(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    return {r5[4:2], g6[5:3], b5[4:3]};
  endfunction

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_count++;
      check("sb_write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(exp_item[AW+7:8]));
        check("wr_data", 32'(mem_data), 32'(exp_item[7:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    px_data = b;
    tick();
  endtask

  task automatic push_px(input int p, input logic [7:0] hi, input logic [7:0] lo);
    if (p < H && tb_line < V)
      exp_q.push_back({AW'(tb_line * H + p), rgb_model(hi, lo)});
  endtask

  task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo,
                           input bit odd, input bit live);
    for (int p = 0; p < npix; p++) begin
      send_byte(hi);
      if (live) push_px(p, hi, lo);
      send_byte(lo);
    end
    if (odd) send_byte(8'hA5);
    href = 1'b0;
    px_data = 8'h00;
    tick();
    tick();
    $display("line %0d: %0d px %0h/%0h odd=%0d live=%0d pending=%0d",
             tb_line, npix, hi, lo, odd, live, exp_q.size());
    if (live) tb_line++;
  endtask

  task automatic vsync_pulse();
    href = 1'b0;
    px_data = 8'h00;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    tb_line = 0;
  endtask

  task automatic start_capture(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_done_clr"}, 32'(done), 32'd0);
    check({name, "_err_clr"}, 32'(frame_err), 32'd0);
    $display("%s: start accepted", name);
  endtask

  task automatic end_frame(input bit with_start, input int exp_wr, input logic exp_err,
                           input string name);
    href = 1'b0;
    vsync = 1'b1;
    start = with_start;
    check({name, "_done_before_edge"}, 32'(done), 32'd0);
    tick();
    start = 1'b0;
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
    check({name, "_frame_err"}, 32'(frame_err), 32'(exp_err));
    check({name, "_writes"}, 32'(wr_count), 32'(exp_wr));
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
    check({name, "_done_held"}, 32'(done), 32'd1);
    check({name, "_busy_held"}, 32'(busy), 32'd0);
    $display("%s: writes=%0d done=%0d frame_err=%0d", name, wr_count, done, frame_err);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Camera activity before any start: nothing may be written
    vsync_pulse();
    send_line(20, 8'hF8, 8'h00, 1'b0, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Frame aborted by reset at pixel 5000
    start_capture("abort_start");
    wr_count = 0;
    vsync_pulse();
    for (int l = 0; l < 31; l++)
      send_line(H, 8'(l * 3), 8'(l * 5 + 1), 1'b0, 1'b1);
    for (int p = 0; p < 40; p++) begin
      send_byte(8'h3C);
      push_px(p, 8'h3C, 8'hD2);
      send_byte(8'hD2);
    end
    send_byte(8'hF8);
    send_byte(8'h00);  // this pixel's write strobe is up now
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(mem_wr_en), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_data", 32'(mem_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(frame_err), 32'd0);
    check("abort_writes", 32'(wr_count), 32'd5000);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("abort: reset asserted after %0d writes", wr_count);
    send_byte(8'hF8);
    send_byte(8'h00);
    rst_n = 1'b1;
    send_line(60, 8'hF8, 8'h00, 1'b0, 1'b0);
    vsync_pulse();
    send_line(H, 8'hF8, 8'h00, 1'b0, 1'b0);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Full pure-red frame, with an ignored start mid-capture
    start_capture("frameB_start");
    wr_count = 0;
    vsync_pulse();
    for (int l = 0; l < V; l++) begin
      send_line(H, 8'hF8, 8'h00, 1'b0, 1'b1);
      if (l == 60) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("frameB_start_ignored_busy", 32'(busy), 32'd1);
        check("frameB_start_ignored_done", 32'(done), 32'd0);
      end
    end
    end_frame(1'b0, 19200, 1'b0, "frameB");

    // Start arrives mid-line: nothing stored until after the next vsync pulse
    for (int p = 0; p < 10; p++) begin
      send_byte(8'h07);
      send_byte(8'hE0);
    end
    start = 1'b1;
    send_byte(8'h12);
    start = 1'b0;
    check("frameC_start_busy", 32'(busy), 32'd1);
    check("frameC_start_done_clr", 32'(done), 32'd0);
    send_line(30, 8'h07, 8'hE0, 1'b0, 1'b0);
    wr_count = 0;
    vsync_pulse();
    for (int l = 0; l < V; l++) begin
      case (l)
        0:       send_line(H,     8'h07, 8'hE0, 1'b0, 1'b1);
        1:       send_line(H,     8'h00, 8'h1F, 1'b0, 1'b1);
        2:       send_line(H + 2, 8'hF8, 8'h00, 1'b0, 1'b1);
        5:       send_line(150,   8'h6B, 8'h4D, 1'b0, 1'b1);
        7:       send_line(H,     8'h9C, 8'h75, 1'b1, 1'b1);
        default: send_line(H, 8'(l * 37 + 11), 8'(l * 91 + 5), 1'b0, 1'b1);
      endcase
    end
    // start coincides with the ending vsync rise and must be ignored
    end_frame(1'b1, 19190, 1'b1, "frameC");

    // Frame with no lines at all
    start_capture("frameD_start");
    wr_count = 0;
    vsync_pulse();
    end_frame(1'b0, 0, 1'b1, "frameD");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
